zq_axi_rd_arbiter: RTL
======================

Name: zq_axi_rd_arbiter

Overview:
- Shares the single 64-bit AXI read master port toward the PS HP slave between two read requesters.
- Port 0 is display refresh fetch (latency-critical). Port 1 is geometry/vertex DMA fetch.
- Arbitrates the AR channel, tags bursts with per-port IDs, routes R beats back by RID and bounds outstanding bursts per port.
- Sits inside the core between the internal fetch units and the o_ar*_m / i_r*_m master pins.

Parameters:
- P_MAX_OUT, 4: max outstanding read bursts per port (1..7).
- P_STARVE, 16: cycles port 1 may wait while eligible before it takes priority over port 0 (1..255).

Ports:
- clk_core  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- i_req_valid0  in  1  port 0 burst request valid.
- o_req_ready0  out  1  port 0 request accepted.
- i_req_addr0  in  32  port 0 burst byte address.
- i_req_len0  in  5  port 0 AXI len (beats-1).
- i_req_valid1, o_req_ready1, i_req_addr1, i_req_len1: as port 0, for port 1.
- o_rvalid0  out  1  port 0 read beat valid.
- o_rdata0  out  64  port 0 read data.
- o_rlast0  out  1  port 0 last beat.
- i_rready0  in  1  port 0 accepts beat.
- o_rvalid1, o_rdata1, o_rlast1, i_rready1: as port 0, for port 1.
- o_arid_m  out  3  AR ID.
- o_araddr_m  out  32  AR address.
- o_arlen_m  out  5  AR len.
- o_arvalid_m  out  1  AR valid.
- i_arready_m  in  1  AR ready.
- i_rid_m  in  3  R ID.
- i_rdata_m  in  64  R data.
- i_rlast_m  in  1  R last.
- i_rvalid_m  in  1  R valid.
- o_rready_m  out  1  R ready.
- o_err  out  1  sticky flag: R beat with unknown ID.

Behaviour:
- Reset values: o_arvalid_m=0, o_arid_m=0, o_araddr_m=0, o_arlen_m=0, o_req_ready0/1=0, o_err=0. All outstanding counters and the starvation counter are 0. FSM is in IDLE.
- Constant outputs: o_arsize_m is fixed at 3 and o_arburst_m at INCR. These are tied off outside the block.
- Eligibility: port n is eligible when i_req_validn=1 and outstanding_n < P_MAX_OUT.
- FSM IDLE:
  - If any port is eligible, pick a winner and pulse o_req_readyn for one cycle.
  - On the same edge, register addr, len and ID (port 0 -> 3'd0, port 1 -> 3'd1). Go to ISSUE.
- Selection rule:
  - Port 0 wins, unless port 1 is eligible and starve_cnt >= P_STARVE, in which case port 1 wins.
  - If only one port is eligible, that port wins.
- Starvation counter:
  - Increments (saturating at 255) every cycle port 1 is eligible and not granted.
  - Clears when port 1 is granted.
- FSM ISSUE:
  - o_arvalid_m=1, with payload held stable.
  - On i_arready_m=1: outstanding_n increments, o_arvalid_m drops next cycle, go to IDLE.
  - Peak throughput is one AR every 2 cycles. Latency from request to arvalid is 1 cycle.
- R routing (combinational):
  - i_rid_m=0 routes to port 0 and i_rid_m=1 routes to port 1. o_rdata/o_rlast are forwarded; o_rvalidn = i_rvalid_m & (rid==n).
  - o_rready_m = i_rreadyn of the selected port.
  - The non-selected port has o_rvalid=0.
- Unknown ID (i_rid_m > 1): o_rready_m=1, the beat is dropped, and o_err is set on i_rvalid_m. o_err clears only on rst.
- Completion: outstanding_n decrements on i_rvalid_m & o_rready_m & i_rlast_m with rid==n.
- Simultaneous increment and decrement on one port leaves the counter unchanged.
- Underflow is impossible by construction. A completion on a port with count 0 is treated like an unknown ID and sets o_err.
- Full: a port at P_MAX_OUT is ineligible, and its request waits with o_req_ready=0. Requesters must hold valid/addr/len stable until ready.
- Reset mid-burst: all state clears and AR is dropped. Any in-flight R beats still arriving after reset are routed by ID. Decrement saturates at 0 with no o_err, for 2*P_MAX_OUT*32 cycles after reset.

Optional Feature:
- ZQ_ARB_RR_EN defined:
  - Selection is strict round-robin. The last-granted port has lowest priority when both ports are eligible.
  - The starvation counter and P_STARVE are unused.
- Not defined: fixed priority plus starvation escape, as described in Behaviour.

Test Plan:
- Single port 0 request, addr=0x1000_0000, len=15, arready=1 → o_req_ready0 pulses cycle 1, arvalid cycle 2 with arid=0, addr/len matched. 16 beats arrive on rid=0 → o_rvalid0 ×16, rlast on the 16th, outstanding returns to 0.
- Both ports request continuously, P_STARVE=16 → port 0 wins repeatedly. Port 1 is granted once starve_cnt reaches 16, then the counter clears. With ZQ_ARB_RR_EN the grants alternate 0,1,0,1.
- Port 0 issues 4 bursts with no R response, P_MAX_OUT=4 → 5th request is held with o_req_ready0=0 while port 1 is still granted. One rlast on rid=0 → port 0 is granted on the following IDLE.
- arready held low 10 cycles → o_arvalid_m stays 1 with stable payload. No new o_req_ready pulses occur until the handshake.
- Interleaved R beats rid=1,0,1 with i_rready1=0 on beat 1 → o_rready_m=0 that cycle and the beat is held. Data reaches the correct ports.
- R beat with rid=5 → o_rready_m=1, no port sees valid, o_err=1 and stays set until rst.

Source files
------------

// File: rtl/zq_axi_rd_arbiter.sv
// zq_axi_rd_arbiter: shares one AXI read master between display (port 0) and DMA (port 1) fetch.
// Default is fixed priority with starvation escape; define ZQ_ARB_RR_EN for round-robin selection.
module zq_axi_rd_arbiter #(
  parameter int P_MAX_OUT = 4,
  parameter int P_STARVE  = 16
) (
  input  logic        clk_core,
  input  logic        rst,
  input  logic        i_req_valid0,
  output logic        o_req_ready0,
  input  logic [31:0] i_req_addr0,
  input  logic [4:0]  i_req_len0,
  input  logic        i_req_valid1,
  output logic        o_req_ready1,
  input  logic [31:0] i_req_addr1,
  input  logic [4:0]  i_req_len1,
  output logic        o_rvalid0,
  output logic [63:0] o_rdata0,
  output logic        o_rlast0,
  input  logic        i_rready0,
  output logic        o_rvalid1,
  output logic [63:0] o_rdata1,
  output logic        o_rlast1,
  input  logic        i_rready1,
  output logic [2:0]  o_arid_m,
  output logic [31:0] o_araddr_m,
  output logic [4:0]  o_arlen_m,
  output logic        o_arvalid_m,
  input  logic        i_arready_m,
  input  logic [2:0]  i_rid_m,
  input  logic [63:0] i_rdata_m,
  input  logic        i_rlast_m,
  input  logic        i_rvalid_m,
  output logic        o_rready_m,
  output logic        o_err
);
  typedef enum logic {IDLE, ISSUE} state_t;
  localparam logic [2:0] MAX_OUT = 3'(P_MAX_OUT);
  localparam logic [8:0] GRACE   = 9'(2 * P_MAX_OUT * 32);
  state_t      state_q;
  logic        arvalid_q;
  logic [2:0]  arid_q;
  logic [31:0] araddr_q;
  logic [4:0]  arlen_q;
  logic [2:0]  out0_q, out1_q, out0_d, out1_d;
  logic [8:0]  grace_q;
  logic        err_q, err_d;
  logic        elig0, elig1, grant1, go, sel0, sel1, ar_hs, done0, done1, dec0, dec1;
`ifdef ZQ_ARB_RR_EN
  logic        last_q;
`else
  logic [7:0]  starve_q;
`endif
  assign elig0 = i_req_valid0 && (out0_q < MAX_OUT);
  assign elig1 = i_req_valid1 && (out1_q < MAX_OUT);
`ifdef ZQ_ARB_RR_EN
  assign grant1 = elig1 && (!elig0 || !last_q);
`else
  assign grant1 = elig1 && (!elig0 || starve_q >= 8'(P_STARVE));
`endif
  assign go           = !rst && state_q == IDLE && (elig0 || elig1);
  assign o_req_ready0 = go && !grant1;
  assign o_req_ready1 = go && grant1;
  assign sel0       = i_rid_m == 3'd0;
  assign sel1       = i_rid_m == 3'd1;
  assign o_rvalid0  = i_rvalid_m && sel0;
  assign o_rvalid1  = i_rvalid_m && sel1;
  assign o_rdata0   = i_rdata_m;
  assign o_rdata1   = i_rdata_m;
  assign o_rlast0   = i_rlast_m;
  assign o_rlast1   = i_rlast_m;
  // beats with an unknown ID are always accepted so the bus never stalls on them
  assign o_rready_m = sel0 ? i_rready0 : (sel1 ? i_rready1 : 1'b1);
  assign ar_hs = arvalid_q && i_arready_m;
  assign done0 = i_rvalid_m && o_rready_m && i_rlast_m && sel0;
  assign done1 = i_rvalid_m && o_rready_m && i_rlast_m && sel1;
  assign dec0  = done0 && out0_q != 3'd0;
  assign dec1  = done1 && out1_q != 3'd0;
  assign out0_d = out0_q + {2'b0, ar_hs && arid_q == 3'd0} - {2'b0, dec0};
  assign out1_d = out1_q + {2'b0, ar_hs && arid_q == 3'd1} - {2'b0, dec1};
  // stray completions right after reset belong to bursts issued before it
  assign err_d = err_q || (i_rvalid_m && !sel0 && !sel1) ||
                 (grace_q == 9'd0 && ((done0 && !dec0) || (done1 && !dec1)));
  always_ff @(posedge clk_core) begin
    if (rst) begin
      state_q   <= IDLE;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      out0_q    <= '0;
      out1_q    <= '0;
      err_q     <= 1'b0;
      grace_q   <= GRACE;
`ifdef ZQ_ARB_RR_EN
      last_q    <= 1'b1;
`else
      starve_q  <= '0;
`endif
    end else begin
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      err_q   <= err_d;
      grace_q <= grace_q - {8'b0, grace_q != 9'd0};
      if (go) begin
        state_q   <= ISSUE;
        arvalid_q <= 1'b1;
        arid_q    <= {2'b0, grant1};
        araddr_q  <= grant1 ? i_req_addr1 : i_req_addr0;
        arlen_q   <= grant1 ? i_req_len1 : i_req_len0;
      end else if (ar_hs) begin
        state_q   <= IDLE;
        arvalid_q <= 1'b0;
      end
`ifdef ZQ_ARB_RR_EN
      if (go) last_q <= grant1;
`else
      starve_q <= (go && grant1) ? 8'd0 :
                  (elig1 && starve_q != 8'hff) ? starve_q + 8'd1 : starve_q;
`endif
    end
  end
  assign o_arvalid_m = arvalid_q;
  assign o_arid_m    = arid_q;
  assign o_araddr_m  = araddr_q;
  assign o_arlen_m   = arlen_q;
  assign o_err       = err_q;
endmodule
